// File: rtl/fft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : fft_pkg                                                      |
// | Purpose   : Shared types and sizes for the 4-point FFT sequencer.        |
// |             seq_state_t encodes the sequencer FSM (LOAD/COMPUTE/OUTPUT). |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package fft_pkg;

  localparam int N_SAMPLES = 4;
  localparam int ADDR_W    = 2;
  localparam int SAMPLE_W  = 8;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } seq_state_t;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : sync_edge_det                                                |
// | Purpose   : Multi-flop synchroniser for an asynchronous input followed   |
// |             by a rising-edge detector producing a 1-cycle pulse.         |
// | Ports     : clk      in  clock                                           |
// |             rst_n    in  asynchronous active-low reset                   |
// |             async_in in  asynchronous level input                        |
// |             rise     out 1-cycle pulse on a synchronised 0->1 transition |
// | Params    : SYNC_STAGES  number of synchroniser flops (>= 2)             |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // The chain samples every cycle regardless of any enable upstream, so a
  // level change seen while the consumer is frozen never turns into a late
  // edge once it resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/fft_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : fft_seq_ctrl                                                 |
// | Purpose   : Sequencer for the 4-point FFT engine. Turns asynchronous     |
// |             host write strobes into sample-store load pulses, launches   |
// |             the butterfly once a frame is stored, then steps the result  |
// |             select under host acknowledge.                               |
// | Ports     : clk, rst_n (async active-low), ena (freeze), clr (soft clear)|
// |             load_strobe/data_in      host sample write                   |
// |             bfly_done                butterfly completion pulse          |
// |             out_ack                  host read acknowledge               |
// |             mem_load_pulse/mem_addr/mem_data  sample-store load port     |
// |             bfly_start               butterfly launch pulse              |
// |             out_sel/out_valid        result read-out                     |
// |             busy/state_o             status / debug                      |
// |             overrun_cnt              dropped-strobe count (macro only)   |
// | Macro     : FFT_SEQ_OVERRUN_EN  adds overrun_cnt port and counter        |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef FFT_SEQ_OVERRUN_EN
  , parameter int OVR_W = 4
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                clr,
  input  logic                load_strobe,
  input  logic [SAMPLE_W-1:0] data_in,
  input  logic                bfly_done,
  input  logic                out_ack,
  output logic                mem_load_pulse,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_data,
  output logic                bfly_start,
  output logic [ADDR_W-1:0]   out_sel,
  output logic                out_valid,
  output logic                busy,
  output logic [1:0]          state_o
`ifdef FFT_SEQ_OVERRUN_EN
  , output logic [OVR_W-1:0]  overrun_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SAMPLES - 1);

  logic rise;

  seq_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic                full_q, full_d;
  logic [ADDR_W-1:0]   sel_q, sel_d;
  logic                load_pulse_q, load_pulse_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                start_q, start_d;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (load_strobe),
    .rise     (rise)
  );

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      count_q      <= '0;
      full_q       <= 1'b0;
      sel_q        <= '0;
      load_pulse_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      full_q       <= full_d;
      sel_q        <= sel_d;
      load_pulse_q <= load_pulse_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      start_q      <= start_d;
    end
  end

  // Next-state / next-output logic. Pulses default low so that both clr and
  // a low ena produce no pulse; everything else holds unless updated.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    full_d       = full_q;
    sel_d        = sel_q;
    load_pulse_d = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    start_d      = 1'b0;

    if (clr) begin
      state_d = ST_LOAD;
      count_d = '0;
      full_d  = 1'b0;
      sel_d   = '0;
    end else if (ena) begin
      case (state_q)
        ST_LOAD: begin
          // full_q marks that the last sample was written on the previous
          // enabled edge; the launch happens one cycle after that write so
          // bfly_start never coincides with the final load pulse.
          if (full_q) begin
            state_d = ST_COMPUTE;
            start_d = 1'b1;
            full_d  = 1'b0;
          end else if (rise) begin
            load_pulse_d = 1'b1;
            addr_d       = count_q;
            data_d       = data_in;
            count_d      = count_q + 1'b1;
            if (count_q == LAST_IDX) begin
              full_d = 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (bfly_done) begin
            state_d = ST_OUTPUT;
            sel_d   = '0;
          end
        end
        ST_OUTPUT: begin
          if (out_ack) begin
            if (sel_q == LAST_IDX) begin
              state_d = ST_LOAD;
              sel_d   = '0;
            end else begin
              sel_d = sel_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end
  end

`ifdef FFT_SEQ_OVERRUN_EN
  logic             drop;
  logic [OVR_W-1:0] ovr_q;

  // A rise is dropped whenever it is not accepted as a write while the
  // sequencer is actually advancing.
  always_comb begin
    drop = 1'b0;
    if (!clr && ena && rise) begin
      drop = (state_q == ST_COMPUTE) || (state_q == ST_OUTPUT) ||
             ((state_q == ST_LOAD) && full_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= '0;
    end else if (clr) begin
      ovr_q <= '0;
    end else if (drop && (ovr_q != {OVR_W{1'b1}})) begin
      ovr_q <= ovr_q + 1'b1;
    end
  end

  assign overrun_cnt = ovr_q;
`endif

  assign mem_load_pulse = load_pulse_q;
  assign mem_addr       = addr_q;
  assign mem_data       = data_q;
  assign bfly_start     = start_q;
  assign out_sel        = sel_q;
  assign state_o        = state_q;
  assign out_valid      = (state_q == ST_OUTPUT);
  assign busy           = (state_q == ST_COMPUTE) || (state_q == ST_OUTPUT);

endmodule : fft_seq_ctrl
`default_nettype wire

// File: tb/tb_fft_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_fft_seq_ctrl                                              |
// | Purpose   : Self-checking bench for fft_seq_ctrl. A frame-level model    |
// |             predicts every output each cycle; directed sequences pin the |
// |             model with literal expectations, then random traffic runs.   |
// | Macro     : FFT_SEQ_OVERRUN_EN  enables overrun_cnt checks               |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fft_seq_ctrl;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       clr;
  logic       load_strobe;
  logic [7:0] data_in;
  logic       bfly_done;
  logic       out_ack;
  logic       mem_load_pulse;
  logic [1:0] mem_addr;
  logic [7:0] mem_data;
  logic       bfly_start;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       busy;
  logic [1:0] state_o;
`ifdef FFT_SEQ_OVERRUN_EN
  logic [3:0] overrun_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fft_seq_ctrl #(
    .SYNC_STAGES (S)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .clr            (clr),
    .load_strobe    (load_strobe),
    .data_in        (data_in),
    .bfly_done      (bfly_done),
    .out_ack        (out_ack),
    .mem_load_pulse (mem_load_pulse),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .bfly_start     (bfly_start),
    .out_sel        (out_sel),
    .out_valid      (out_valid),
    .busy           (busy),
    .state_o        (state_o)
`ifdef FFT_SEQ_OVERRUN_EN
    , .overrun_cnt  (overrun_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model. Phase 0 = collecting a frame, 1 = butterfly running,
  // 2 = results being read. samp[] holds the strobe level seen at previous
  // edges (samp[0] most recent); a write is triggered when the level seen
  // S edges ago is high and the one before it was low.
  // ---------------------------------------------------------------------
  int         m_phase, m_written, m_sel, m_addr, m_ovr;
  bit         m_pending, m_pulse, m_start, m_rise, m_drop;
  logic [7:0] m_data;
  bit         samp [0:S];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_written = 0; m_sel = 0; m_addr = 0; m_ovr = 0;
      m_pending = 0; m_pulse = 0; m_start = 0; m_data = 8'h00;
      for (int k = 0; k <= S; k++) samp[k] = 1'b0;
    end else begin
      m_rise = samp[S-1] && !samp[S];
      for (int k = S; k > 0; k--) samp[k] = samp[k-1];
      samp[0] = load_strobe;
      m_pulse = 0;
      m_start = 0;
      m_drop  = 0;
      if (clr) begin
        m_phase = 0; m_written = 0; m_sel = 0; m_pending = 0; m_ovr = 0;
      end else if (ena) begin
        if (m_phase == 0 && m_pending) begin
          m_phase = 1; m_start = 1; m_pending = 0; m_drop = m_rise;
        end else if (m_phase == 0) begin
          if (m_rise) begin
            m_pulse   = 1;
            m_addr    = m_written;
            m_data    = data_in;
            m_written = (m_written + 1) % 4;
            if (m_written == 0) m_pending = 1;
          end
        end else begin
          m_drop = m_rise;
          if (m_phase == 1 && bfly_done) begin
            m_phase = 2; m_sel = 0;
          end else if (m_phase == 2 && out_ack) begin
            if (m_sel == 3) begin m_phase = 0; m_sel = 0; end
            else m_sel = m_sel + 1;
          end
        end
        if (m_drop && m_ovr < 15) m_ovr = m_ovr + 1;
      end
    end
    #1;
    chk("pulse", mem_load_pulse, m_pulse);
    chk("addr", mem_addr, m_addr);
    chk("data", mem_data, m_data);
    chk("start", bfly_start, m_start);
    chk("sel", out_sel, m_sel);
    chk("state", state_o, m_phase);
    chk("valid", out_valid, m_phase == 2);
    chk("busy", busy, m_phase != 0);
`ifdef FFT_SEQ_OVERRUN_EN
    chk("ovr", overrun_cnt, m_ovr);
`endif
  end

  // ---------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------
  task automatic send_sample(input logic [7:0] d, output int lat, output logic [1:0] a,
                             output logic [7:0] md, output logic st_after);
    lat = -1; a = 2'd0; md = 8'h00; st_after = 1'b0;
    @(negedge clk);
    data_in = d;
    load_strobe = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (mem_load_pulse) begin
        lat = i; a = mem_addr; md = mem_data;
        @(posedge clk); #1;
        st_after = bfly_start;
        break;
      end
    end
    @(negedge clk);
    load_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic strobe_count(input int hold, output int n);
    n = 0;
    @(negedge clk);
    load_strobe = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (mem_load_pulse) n++;
    end
    @(negedge clk);
    load_strobe = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_load_pulse) n++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, n, run;
    logic [1:0] a;
    logic [7:0] md;
    logic       st;
    logic [7:0] frame [0:3];
    frame[0] = 8'h12; frame[1] = 8'h34; frame[2] = 8'h56; frame[3] = 8'h78;

    rst_n = 1'b0; ena = 1'b1; clr = 1'b0; load_strobe = 1'b0;
    data_in = 8'h00; bfly_done = 1'b0; out_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {mem_load_pulse, mem_addr, mem_data, bfly_start, out_sel,
                     out_valid, busy, state_o}, 0);
    rst_n = 1'b1;

    // Reset in the middle of a frame (two samples stored).
    send_sample(8'hA5, lat, a, md, st);
    send_sample(8'h5A, lat, a, md, st);
    chk("pre_rst_addr", a, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {mem_load_pulse, mem_addr, mem_data, bfly_start, out_sel,
                      out_valid, busy, state_o}, 0);
    @(posedge clk); #1;
    chk("rst_state", state_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_sample(8'hC3, lat, a, md, st);
    chk("rst_first_addr", a, 0);

    // Held strobe produces a single write.
    strobe_count(10, n);
    chk("held_one", n, 1);

    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;

    // Full frame: latency, address, data and launch timing.
    for (int i = 0; i < 4; i++) begin
      send_sample(frame[i], lat, a, md, st);
      chk("load_lat", lat, 3);
      chk("load_addr", a, i);
      chk("load_data", md, frame[i]);
      chk("load_start", st, (i == 3) ? 1 : 0);
    end
    chk("compute_state", state_o, 1);
    chk("compute_busy", busy, 1);

    // Strobes while computing are dropped.
    run = 0;
    for (int i = 0; i < 3; i++) begin
      strobe_count(2, n);
      run += n;
    end
    chk("drop_none", run, 0);
`ifdef FFT_SEQ_OVERRUN_EN
    chk("drop_ovr", overrun_cnt, 3);
`endif

    // Freeze across a strobe and a bfly_done.
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ena = 1'b0;
      load_strobe = (i < 2);
      bfly_done = (i == 1);
      @(posedge clk); #1;
      if (mem_load_pulse) n++;
      if (state_o != 2'd1) n++;
    end
    @(negedge clk);
    ena = 1'b1; bfly_done = 1'b0; load_strobe = 1'b0;
    chk("ena_freeze", n, 0);
    repeat (2) @(negedge clk);
    chk("ena_resume", state_o, 1);
`ifdef FFT_SEQ_OVERRUN_EN
    chk("ena_ovr", overrun_cnt, 3);
`endif

    // Butterfly done, then read out four bins.
    bfly_done = 1'b1;
    @(negedge clk);
    bfly_done = 1'b0;
    chk("out_valid", out_valid, 1);
    chk("out_sel0", out_sel, 0);
    for (int k = 0; k < 4; k++) begin
      out_ack = 1'b1;
      @(negedge clk);
      out_ack = 1'b0;
      if (k < 3) begin
        chk("ack_sel", out_sel, k + 1);
        chk("ack_state", state_o, 2);
      end else begin
        chk("ack_last_state", state_o, 0);
        chk("ack_last_sel", out_sel, 0);
      end
    end

    // Soft clear restarts the frame at address 0.
    send_sample(8'h01, lat, a, md, st);
    send_sample(8'h02, lat, a, md, st);
    chk("pre_clr_addr", a, 1);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_state", state_o, 0);
    send_sample(8'h03, lat, a, md, st);
    chk("clr_addr", a, 0);

    // Random traffic against the model.
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (run == 0) begin
        load_strobe = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 5);
      end else begin
        run--;
      end
      if (!load_strobe) data_in = 8'($urandom);
      ena       = ($urandom_range(0, 9) != 0);
      clr       = ($urandom_range(0, 59) == 0);
      bfly_done = ($urandom_range(0, 5) == 0);
      out_ack   = ($urandom_range(0, 2) == 0);
      rst_n     = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; ena = 1'b1; clr = 1'b0; load_strobe = 1'b0;
    bfly_done = 1'b0; out_ack = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fft_seq_ctrl
`default_nettype wire
